alu_issue_stage: RTL and testbench

Operand-fetch, issue and write-back stage sitting directly upstream of `ALU`. It accepts 16-bit register-register instructions through a valid/ready handshake and reads two source operands from a 16-entry register file. It drives `A`, `B` and `opcode` into the ALU, then writes the ALU's registered result back to the destination register. It tracks the ALU's one-cycle latency, stalls read-after-write hazards on the in-flight instruction, and forwards the result that is about to be written.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_issue_stage_if.sv | 33 +++
 rtl/regfile_16xn.sv | 48 ++++
 rtl/alu_issue_stage.sv | 106 ++++++++++
 tb/tb_alu_issue_stage.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the ALU issue stage and the ALU it feeds: the 4-bit
// opcode constants, the bit positions of the instruction fields, the
// in-flight slot record and the opcode legality check.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_XOR = 4'd1;
   localparam logic [3:0] OP_OR  = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_SEQ = 4'd4;
   localparam logic [3:0] OP_SLT = 4'd5;
   localparam logic [3:0] OP_SL  = 4'd6;
   localparam logic [3:0] OP_SR  = 4'd7;

   // Instruction layout: op | rd | rs1 | rs2
   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int RS1_MSB = 7;
   localparam int RS1_LSB = 4;
   localparam int RS2_MSB = 3;
   localparam int RS2_LSB = 0;

   // One in-flight instruction as seen by the hazard/write-back logic
   typedef struct packed {
      logic       valid;
      logic [3:0] rd;
      logic       wr_en;
   } slot_t;

   // Opcodes 0..7 are defined; 8..15 are illegal
   function automatic logic is_legal(input logic [3:0] op);
      return (op <= OP_SR);
   endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// -----------------------------------------------------------------------------
// alu_issue_stage_if
// Bundles the instruction handshake, the ALU operand/result bus and the
// write-back/status outputs of alu_issue_stage.
//   slave  : the issue stage (takes instructions and alu_out, drives the rest)
//   master : the environment (upstream instruction source plus the ALU)
// -----------------------------------------------------------------------------
interface alu_issue_stage_if #(
   parameter int N = 16
);
   logic         in_valid;
   logic [15:0]  in_instr;
   logic         in_ready;
   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   logic [3:0]   alu_op;
   logic [N-1:0] alu_out;
   logic         wb_valid;
   logic [3:0]   wb_rd;
   logic [N-1:0] wb_data;
   logic         illegal;
   logic         busy;

   modport master (
      output in_valid, in_instr, alu_out,
      input  in_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data, illegal, busy
   );

   modport slave (
      input  in_valid, in_instr, alu_out,
      output in_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data, illegal, busy
   );
endinterface

// File: rtl/regfile_16xn.sv
// -----------------------------------------------------------------------------
// regfile_16xn
// 16 x N register file: two combinational read ports, one synchronous write
// port. Entry 0 is hard-wired to zero (writes to it are dropped).
//   clk, rst_n            : clock, asynchronous active-low clear of all entries
//   rd_addr_a/rd_data_a   : read port A
//   rd_addr_b/rd_data_b   : read port B
//   wr_en/wr_addr/wr_data : write port, committed on the rising edge
// -----------------------------------------------------------------------------
module regfile_16xn #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [3:0]   rd_addr_a,
   output logic [N-1:0] rd_data_a,
   input  logic [3:0]   rd_addr_b,
   output logic [N-1:0] rd_data_b,
   input  logic         wr_en,
   input  logic [3:0]   wr_addr,
   input  logic [N-1:0] wr_data
);

   logic [15:0][N-1:0] entries;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_entry
         if (gi == 0) begin : g_zero
            assign entries[gi] = '0;
         end else begin : g_reg
            logic [N-1:0] value_reg;
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  value_reg <= '0;
               end else if (wr_en && (wr_addr == 4'(gi))) begin
                  value_reg <= wr_data;
               end
            end
            assign entries[gi] = value_reg;
         end
      end
   endgenerate

   assign rd_data_a = entries[rd_addr_a];
   assign rd_data_b = entries[rd_addr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Operand fetch, issue and write-back for a one-cycle-latency ALU.
// Reads rs1/rs2 from a 16-entry register file, registers A/B/opcode into the
// ALU, and writes the ALU's registered result back two edges after issue.
//   clk   : clock shared with the ALU
//   rst_n : asynchronous active-low reset
//   bus   : alu_issue_stage_if.slave (handshake, ALU bus, write-back, status)
// Slot s1 = instruction the ALU is computing, s2 = instruction whose result is
// on alu_out. A read of s1.rd stalls; a read of s2.rd is forwarded.
// -----------------------------------------------------------------------------
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int N = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_issue_stage_if.slave  bus
);

   logic [3:0]   instr_op;
   logic [3:0]   instr_rd;
   logic [3:0]   instr_rs1;
   logic [3:0]   instr_rs2;
   logic [N-1:0] rf_data_a;
   logic [N-1:0] rf_data_b;
   logic [N-1:0] opnd_a;
   logic [N-1:0] opnd_b;
   logic         hazard;
   logic         accept;
   logic         wb_en;

   slot_t        s1_reg;
   slot_t        s2_reg;
   logic [N-1:0] alu_a_reg;
   logic [N-1:0] alu_b_reg;
   logic [3:0]   alu_op_reg;
   logic         illegal_reg;

   assign instr_op  = bus.in_instr[OP_MSB:OP_LSB];
   assign instr_rd  = bus.in_instr[RD_MSB:RD_LSB];
   assign instr_rs1 = bus.in_instr[RS1_MSB:RS1_LSB];
   assign instr_rs2 = bus.in_instr[RS2_MSB:RS2_LSB];

   // s2's result commits at the next edge; this is also the forwarding source
   assign wb_en = s2_reg.valid && s2_reg.wr_en;

   regfile_16xn #(.N(N)) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr_a (instr_rs1),
      .rd_data_a (rf_data_a),
      .rd_addr_b (instr_rs2),
      .rd_data_b (rf_data_b),
      .wr_en     (wb_en),
      .wr_addr   (s2_reg.rd),
      .wr_data   (bus.alu_out)
   );

   always_comb begin
      // s1's result does not exist yet anywhere we can reach, so wait a cycle
      hazard = s1_reg.valid && s1_reg.wr_en &&
               ((instr_rs1 == s1_reg.rd) || (instr_rs2 == s1_reg.rd));
      accept = bus.in_valid && !hazard;
      // wr_en already excludes r0, so a zero source never forwards
      opnd_a = (wb_en && (instr_rs1 == s2_reg.rd)) ? bus.alu_out : rf_data_a;
      opnd_b = (wb_en && (instr_rs2 == s2_reg.rd)) ? bus.alu_out : rf_data_b;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_reg      <= '0;
         s2_reg      <= '0;
         alu_a_reg   <= '0;
         alu_b_reg   <= '0;
         alu_op_reg  <= OP_ADD;
         illegal_reg <= 1'b0;
      end else begin
         s2_reg      <= s1_reg;
         illegal_reg <= accept && !is_legal(instr_op);
         if (accept) begin
            alu_a_reg  <= opnd_a;
            alu_b_reg  <= opnd_b;
            // Illegal ops still go to the ALU (which then holds its output)
            alu_op_reg <= instr_op;
            s1_reg     <= '{valid: 1'b1,
                            rd:    instr_rd,
                            wr_en: is_legal(instr_op) && (instr_rd != 4'd0)};
         end else begin
            s1_reg <= '0;
         end
      end
   end

   assign bus.in_ready = !hazard;
   assign bus.alu_a    = alu_a_reg;
   assign bus.alu_b    = alu_b_reg;
   assign bus.alu_op   = alu_op_reg;
   assign bus.wb_valid = wb_en;
   assign bus.wb_rd    = s2_reg.rd;
   assign bus.wb_data  = bus.alu_out;
   assign bus.illegal  = illegal_reg;
   assign bus.busy     = s1_reg.valid | s2_reg.valid;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
// Drives alu_issue_stage with directed sequences and random instructions.
// A behavioural ALU (registered, no reset, holds on illegal ops) closes the
// loop. The reference executes instructions in program order on an array of
// 16 registers and predicts, per clock, the write-back, illegal pulse, busy,
// ALU operands and in_ready.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

   localparam int N = 16;

   localparam logic [3:0] ADD = 4'd0, XOR = 4'd1, OR_ = 4'd2, AND_ = 4'd3;
   localparam logic [3:0] SEQ = 4'd4, SLT = 4'd5, SL = 4'd6, SR = 4'd7;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   n_total = 0;
   int   n_pass = 0;

   alu_issue_stage_if #(.N(N)) bus ();

   alu_issue_stage #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] alu_ref(input logic [3:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
      case (op)
         ADD:     return a + b;
         XOR:     return a ^ b;
         OR_:     return a | b;
         AND_:    return a & b;
         SEQ:     return (a == b) ? 16'd1 : 16'd0;
         SLT:     return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
         SL:      return a << b[3:0];
         SR:      return a >> b[3:0];
         default: return 16'd0;
      endcase
   endfunction

   // Behavioural ALU: registered result, no reset, holds on illegal opcodes
   initial bus.alu_out = 16'h5A5A;
   always @(posedge clk) begin
      if (bus.alu_op < 4'd8) bus.alu_out <= alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);
   end

   // ---------------- reference model state ----------------
   typedef struct {
      int          due;
      logic [3:0]  rd;
      logic [15:0] data;
   } wb_t;

   logic [15:0] rf_m [16];
   wb_t         wb_q [$];
   bit          acc_at [int];
   bit          illegal_at [int];
   logic [15:0] ea [int];
   logic [15:0] eb [int];
   logic [3:0]  eo [int];
   int          prev_cyc = -100;
   logic [3:0]  prev_rd = '0;
   logic        prev_wr = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
   endtask

   // One clock: check what earlier edges owe us, then present an instruction
   task automatic tick(input logic v, input logic [15:0] ins, output logic acc);
      logic [3:0]  op, rd, rs1, rs2;
      logic [15:0] a, b, res;
      logic        rdy_exp;
      @(negedge clk);
      if (wb_q.size() > 0 && wb_q[0].due == cyc) begin
         chk("wb_valid", bus.wb_valid, 1);
         chk("wb_rd", bus.wb_rd, wb_q[0].rd);
         chk("wb_data", bus.wb_data, wb_q[0].data);
         void'(wb_q.pop_front());
      end else begin
         chk("wb_idle", bus.wb_valid, 0);
      end
      chk("illegal", bus.illegal, illegal_at.exists(cyc - 1));
      chk("busy", bus.busy, acc_at.exists(cyc - 1) || acc_at.exists(cyc - 2));
      if (ea.exists(cyc - 1)) begin
         chk("alu_a", bus.alu_a, ea[cyc - 1]);
         chk("alu_b", bus.alu_b, eb[cyc - 1]);
         chk("alu_op", bus.alu_op, eo[cyc - 1]);
      end
      bus.in_valid = v;
      bus.in_instr = ins;
      #1;
      {op, rd, rs1, rs2} = ins;
      rdy_exp = !((prev_cyc == cyc - 1) && prev_wr && (rs1 == prev_rd || rs2 == prev_rd));
      chk("in_ready", bus.in_ready, rdy_exp);
      acc = v && bus.in_ready;
      if (acc) begin
         $display("issue cyc=%0d op=%0d rd=r%0d rs1=r%0d rs2=r%0d", cyc, op, rd, rs1, rs2);
         a = rf_m[rs1];
         b = rf_m[rs2];
         ea[cyc] = a;
         eb[cyc] = b;
         eo[cyc] = op;
         acc_at[cyc] = 1'b1;
         prev_wr = 1'b0;
         if (op < 4'd8) begin
            if (rd != 4'd0) begin
               res = alu_ref(op, a, b);
               rf_m[rd] = res;
               wb_q.push_back('{due: cyc + 2, rd: rd, data: res});
               prev_wr = 1'b1;
            end
         end else begin
            illegal_at[cyc] = 1'b1;
         end
         prev_cyc = cyc;
         prev_rd  = rd;
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [3:0] rd,
                        input logic [3:0] rs1, input logic [3:0] rs2, output int stalls);
      logic acc;
      acc = 1'b0;
      stalls = 0;
      for (int t = 0; t < 4 && !acc; t++) begin
         tick(1'b1, {op, rd, rs1, rs2}, acc);
         if (!acc) stalls++;
      end
      if (!acc) chk("issue_timeout", acc, 1);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) tick(1'b0, 16'h0000, acc);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_instr = 16'h0000;
      foreach (rf_m[i]) rf_m[i] = '0;
      wb_q.delete();
      acc_at.delete();
      illegal_at.delete();
      ea.delete();
      eb.delete();
      eo.delete();
      prev_cyc = -100;
      prev_wr  = 1'b0;
      repeat (n) @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_wb_valid", bus.wb_valid, 0);
      chk("rst_illegal", bus.illegal, 0);
      chk("rst_alu_a", bus.alu_a, 0);
      chk("rst_alu_b", bus.alu_b, 0);
      chk("rst_alu_op", bus.alu_op, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int          st;
      logic        acc, pend, v;
      logic [15:0] ins;

      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_instr = 16'h0000;
      do_reset(3);

      // r1 = 5, r2 = 3 built from r0
      issue(SEQ, 4'd1, 4'd0, 4'd0, st);
      issue(ADD, 4'd2, 4'd1, 4'd1, st);
      issue(ADD, 4'd4, 4'd2, 4'd2, st);
      issue(ADD, 4'd2, 4'd2, 4'd1, st);
      issue(ADD, 4'd1, 4'd4, 4'd1, st);
      idle(3);

      // Independent ops: ADD r3 = 8, XOR r4 = 6, no stalls
      issue(ADD, 4'd3, 4'd1, 4'd2, st);
      chk("stall_add_indep", st, 0);
      issue(XOR, 4'd4, 4'd1, 4'd2, st);
      chk("stall_xor_indep", st, 0);
      idle(3);

      // Back-to-back dependency (r3 cleared so only forwarding gives 16)
      issue(AND_, 4'd3, 4'd0, 4'd0, st);
      idle(3);
      issue(ADD, 4'd3, 4'd1, 4'd2, st);
      issue(ADD, 4'd5, 4'd3, 4'd3, st);
      chk("stall_b2b", st, 1);
      idle(3);

      // One-gap dependency: SLT r6,r2,r3 forwards r3, no stall
      issue(AND_, 4'd3, 4'd0, 4'd0, st);
      idle(3);
      issue(ADD, 4'd3, 4'd1, 4'd2, st);
      issue(ADD, 4'd0, 4'd1, 4'd1, st);
      chk("stall_nop_r0", st, 0);
      issue(SLT, 4'd6, 4'd2, 4'd3, st);
      chk("stall_gap", st, 0);
      idle(3);

      // Wrap: r1 = 0xFFFF via x = 2x | 1, then r7 = r1 + r1, r8 = (r7 == r7)
      issue(SEQ, 4'd15, 4'd0, 4'd0, st);
      issue(SEQ, 4'd1, 4'd0, 4'd0, st);
      for (int i = 0; i < 15; i++) begin
         issue(ADD, 4'd1, 4'd1, 4'd1, st);
         issue(OR_, 4'd1, 4'd1, 4'd15, st);
      end
      idle(3);
      issue(ADD, 4'd7, 4'd1, 4'd1, st);
      issue(SEQ, 4'd8, 4'd7, 4'd7, st);
      chk("stall_seq_wrap", st, 1);
      idle(3);

      // Illegal op 0xA targeting r9: pulse, no write, following read of r9 not stalled
      issue(ADD, 4'd9, 4'd1, 4'd0, st);
      idle(3);
      issue(4'hA, 4'd9, 4'd2, 4'd3, st);
      issue(ADD, 4'd10, 4'd9, 4'd0, st);
      chk("stall_after_illegal", st, 0);
      idle(3);

      // Writes to r0 are dropped
      issue(ADD, 4'd0, 4'd1, 4'd1, st);
      issue(ADD, 4'd11, 4'd0, 4'd1, st);
      chk("stall_r0_src", st, 0);
      idle(3);
      issue(ADD, 4'd12, 4'd0, 4'd0, st);
      idle(3);

      // Reset between E0 and E1 of ADD r3
      issue(ADD, 4'd3, 4'd1, 4'd2, st);
      do_reset(2);
      idle(3);
      issue(ADD, 4'd10, 4'd3, 4'd0, st);
      issue(ADD, 4'd12, 4'd1, 4'd2, st);
      idle(3);

      // Random traffic, instruction held while stalled
      pend = 1'b0;
      v    = 1'b0;
      ins  = 16'h0000;
      for (int i = 0; i < 600; i++) begin
         if (!pend) begin
            v   = ($urandom_range(0, 3) != 0);
            ins = 16'($urandom);
            // bias toward legal ops and a few seed writes of 1
            if ($urandom_range(0, 3) != 0) ins[15] = 1'b0;
            if ($urandom_range(0, 15) == 0) ins = {SEQ, ins[11:8], 8'h00};
         end
         tick(v, ins, acc);
         pend = v && !acc;
      end
      idle(4);
      chk("scoreboard_drained", wb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
